// File: rtl/div_8bit_seq.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_ZERO_ERR_EN to add the err port and the short divide-by-zero path.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one restoring step per cycle, eight steps
// DONE  | results valid, done pulse; start here launches a new division
module div_8bit_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic       err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [7:0] dvs_q, dvs_d;
    logic [8:0] prem_q, prem_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
`ifdef DIV_ZERO_ERR_EN
    logic       err_q, err_d;
`endif

    logic [9:0] diff;
    logic       q_bit;
    logic [8:0] next_prem;

    // dvd_q shifts left each step; its MSB feeds the partial remainder and
    // the new quotient bit enters at the LSB, so it ends up holding the quotient.
    always_comb begin
        diff      = {prem_q, dvd_q[7]} - {2'b00, dvs_q};
        q_bit     = ~diff[9];
        next_prem = q_bit ? diff[8:0] : {prem_q[7:0], dvd_q[7]};
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIV_ZERO_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    prem_d  = 9'd0;
                    cnt_d   = 3'd0;
                    state_d = RUN;
`ifdef DIV_ZERO_ERR_EN
                    err_d   = 1'b0;
                    if (divisor == 8'd0) begin
                        err_d   = 1'b1;
                        quo_d   = 8'hFF;
                        rem_d   = dividend;
                        state_d = DONE;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d  = {dvd_q[6:0], q_bit};
                prem_d = next_prem;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quo_d   = {dvd_q[6:0], q_bit};
                    rem_d   = next_prem[7:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= 8'd0;
            dvs_q   <= 8'd0;
            prem_q  <= 9'd0;
            cnt_q   <= 3'd0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
`ifdef DIV_ZERO_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIV_ZERO_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef DIV_ZERO_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_div_8bit_seq.sv
// Directed bench for div_8bit_seq; inputs driven and outputs sampled on the falling edge.
module tb_div_8bit_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
`ifdef DIV_ZERO_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    div_8bit_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Returns with the start edge N just behind us (sampling point after edge N).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts further rising edges until done is seen, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 30) begin
            @(negedge clk);
            edges++;
        end
    endtask

    int lat;
    int gap;
    int done_seen;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quotient, 0);
        chk("rst_rem", remainder, 0);
`ifdef DIV_ZERO_ERR_EN
        chk("rst_err", err, 0);
`endif
        rst = 1'b0;

        // 200 / 7 with full latency and pulse-width checks
        start_op(8'd200, 8'd7);
        chk("200_7_busy", busy, 1);
        wait_done(lat);
        chk("200_7_lat", lat, 8);
        chk("200_7_quo", quotient, 28);
        chk("200_7_rem", remainder, 4);
        @(negedge clk);
        chk("200_7_pulse", done, 0);
        chk("200_7_idle_busy", busy, 0);
        chk("200_7_hold_quo", quotient, 28);

        start_op(8'd255, 8'd1);
        wait_done(lat);
        chk("255_1_lat", lat, 8);
        chk("255_1_quo", quotient, 255);
        chk("255_1_rem", remainder, 0);

        start_op(8'd5, 8'd10);
        wait_done(lat);
        chk("5_10_quo", quotient, 0);
        chk("5_10_rem", remainder, 5);

        // start held high with new operands during RUN must be ignored
        start_op(8'd100, 8'd3);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        chk("100_3_hold_prev_quo", quotient, 0);
        wait_done(lat);
        start = 1'b0;
        chk("100_3_lat", lat, 7);
        chk("100_3_quo", quotient, 33);
        chk("100_3_rem", remainder, 1);
        @(negedge clk);
        chk("100_3_pulse", done, 0);
        chk("100_3_no_restart", busy, 0);

        // reset sampled on the edge of RUN step 4
        start_op(8'd200, 8'd7);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quo", quotient, 0);
        chk("abort_rem", remainder, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);

        // back-to-back: start accepted in DONE
        start_op(8'd20, 8'd6);
        wait_done(lat);
        chk("20_6_quo", quotient, 3);
        chk("20_6_rem", remainder, 2);
        dividend = 8'd9;
        divisor  = 8'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("9_2_restart_busy", busy, 1);
        chk("9_2_hold_quo", quotient, 3);
        wait_done(lat);
        gap = lat + 1;
        chk("9_2_gap", gap, 9);
        chk("9_2_quo", quotient, 4);
        chk("9_2_rem", remainder, 1);

        // divide by zero
        start_op(8'd77, 8'd0);
`ifdef DIV_ZERO_ERR_EN
        chk("77_0_busy", busy, 0);
        wait_done(lat);
        chk("77_0_lat", lat, 0);
        chk("77_0_err", err, 1);
        chk("77_0_quo", quotient, 8'hFF);
        chk("77_0_rem", remainder, 77);
        @(negedge clk);
        chk("77_0_pulse", done, 0);
        start_op(8'd5, 8'd10);
        chk("err_clear_on_start", err, 0);
        wait_done(lat);
        chk("5_10_err", err, 0);
        chk("5_10_quo_b", quotient, 0);
        chk("5_10_rem_b", remainder, 5);
`else
        chk("77_0_busy", busy, 1);
        wait_done(lat);
        chk("77_0_lat", lat, 8);
        chk("77_0_quo", quotient, 8'hFF);
        chk("77_0_rem", remainder, 77);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
